// File: rtl/twiddle_seq_gen.sv
// Twiddle-factor sequencer for one DIT FFT stage: index counter, quarter-wave sine ROM, 3-cycle pipeline.
// Define TWIDDLE_CONJ_EN to add the Inv port (conjugate twiddles for the inverse FFT).
module twiddle_seq_gen #(
    parameter int unsigned B_FFTP = 12,
    parameter int unsigned B_TWD  = 18
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          ClockEn,
    input  logic                          Start,
    input  logic [$clog2(B_FFTP+1)-1:0]   LogN,
    input  logic [$clog2(B_FFTP)-1:0]     Stage,
`ifdef TWIDDLE_CONJ_EN
    input  logic                          Inv,
`endif
    output logic                          Busy,
    output logic                          Valid,
    output logic                          Last,
    output logic signed [B_TWD-1:0]       Re,
    output logic signed [B_TWD-1:0]       Im
);
    localparam int unsigned LW = $clog2(B_FFTP + 1);
    localparam int unsigned SW = $clog2(B_FFTP);
    localparam int unsigned JW = B_FFTP - 1;
    localparam int unsigned QW = B_FFTP - 2;
    localparam int unsigned Q  = 1 << QW;
    localparam logic signed [B_TWD-1:0] ONE = {2'b01, {(B_TWD-2){1'b0}}};
    localparam real PI = 3.14159265358979323846;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    // Quarter-wave sine table, entries rounded to nearest at elaboration
    logic [B_TWD-1:0] rom [Q];
    for (genvar k = 0; k < int'(Q); k++) begin : g_rom
        localparam real ANG = PI * $itor(k) / (2.0 * $itor(Q));
        assign rom[k] = B_TWD'($rtoi($sin(ANG) * $itor(2 ** (B_TWD - 2)) + 0.5));
    end

    state_t                  state_q;
    logic [JW-1:0]           j_q;
    logic [LW-1:0]           logn_q;
    logic [SW-1:0]           stage_q;
`ifdef TWIDDLE_CONJ_EN
    logic                    inv_q;
`endif
    logic [QW-1:0]           addr_a_q, addr_b_q;
    logic                    quad1_q, seam1_q, v1_q, l1_q;
    logic signed [B_TWD-1:0] rd_a_q, rd_b_q;
    logic                    quad2_q, seam2_q, v2_q, l2_q;

    logic                    legal_c, last_j_c;
    logic [JW-1:0]           mask_c, theta_c, jlast_c;
    logic [SW-1:0]           shamt_c;
    logic signed [B_TWD-1:0] re_c, im_c;

    // theta = (j & (2^s-1)) << (B_FFTP-1-s); LogN cancels out of the two shifts
    always_comb begin
        legal_c  = (LogN >= LW'(3)) && (LogN <= LW'(B_FFTP)) && (LW'(Stage) < LogN);
        mask_c   = ~({JW{1'b1}} << stage_q);
        shamt_c  = SW'(B_FFTP - 1) - stage_q;
        theta_c  = (j_q & mask_c) << shamt_c;
        jlast_c  = ~({JW{1'b1}} << (logn_q - LW'(1)));
        last_j_c = (j_q == jlast_c);
    end

    // Quadrant mapping with forced seams at theta = 0 and theta = Q
    always_comb begin
        re_c = '0;
        im_c = '0;
        if (seam2_q) begin
            re_c = quad2_q ? '0 : ONE;
            im_c = quad2_q ? -ONE : '0;
        end else if (!quad2_q) begin
            re_c = rd_a_q;
            im_c = -rd_b_q;
        end else begin
            re_c = -rd_b_q;
            im_c = -rd_a_q;
        end
`ifdef TWIDDLE_CONJ_EN
        if (inv_q) im_c = -im_c;
`endif
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            j_q      <= '0;
            logn_q   <= '0;
            stage_q  <= '0;
`ifdef TWIDDLE_CONJ_EN
            inv_q    <= 1'b0;
`endif
            addr_a_q <= '0;
            addr_b_q <= '0;
            quad1_q  <= 1'b0;
            seam1_q  <= 1'b0;
            v1_q     <= 1'b0;
            l1_q     <= 1'b0;
            rd_a_q   <= '0;
            rd_b_q   <= '0;
            quad2_q  <= 1'b0;
            seam2_q  <= 1'b0;
            v2_q     <= 1'b0;
            l2_q     <= 1'b0;
            Busy     <= 1'b0;
            Valid    <= 1'b0;
            Last     <= 1'b0;
            Re       <= '0;
            Im       <= '0;
        end else if (ClockEn) begin
            v1_q     <= (state_q == S_RUN);
            l1_q     <= (state_q == S_RUN) && last_j_c;
            addr_b_q <= theta_c[QW-1:0];
            addr_a_q <= QW'(0) - theta_c[QW-1:0];
            quad1_q  <= theta_c[QW];
            seam1_q  <= (theta_c[QW-1:0] == '0);

            rd_a_q   <= rom[addr_a_q];
            rd_b_q   <= rom[addr_b_q];
            quad2_q  <= quad1_q;
            seam2_q  <= seam1_q;
            v2_q     <= v1_q;
            l2_q     <= l1_q;

            Valid    <= v2_q;
            Last     <= l2_q;
            if (v2_q) begin
                Re <= re_c;
                Im <= im_c;
            end

            case (state_q)
                S_IDLE: begin
                    if (Start && legal_c) begin
                        logn_q  <= LogN;
                        stage_q <= Stage;
`ifdef TWIDDLE_CONJ_EN
                        inv_q   <= Inv;
`endif
                        j_q     <= '0;
                        state_q <= S_RUN;
                        Busy    <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (last_j_c) begin
                        j_q     <= '0;
                        state_q <= S_DRAIN;
                    end else begin
                        j_q <= j_q + JW'(1);
                    end
                end
                S_DRAIN: begin
                    // j doubles as the drain counter
                    if (j_q == JW'(2)) begin
                        j_q     <= '0;
                        state_q <= S_IDLE;
                        Busy    <= 1'b0;
                    end else begin
                        j_q <= j_q + JW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_twiddle_seq_gen.sv
// Directed bench for twiddle_seq_gen: expected twiddles from a cos/sin model, queued at Start, compared on Valid.
module tb_twiddle_seq_gen;
    localparam real PI = 3.14159265358979323846;

    logic              Clock = 1'b0;
    logic              Reset;
    logic              ClockEn;
    logic              Start;
    logic [3:0]        LogN;
    logic [3:0]        Stage;
`ifdef TWIDDLE_CONJ_EN
    logic              Inv;
`endif
    logic              Busy, Valid, Last;
    logic signed [17:0] Re, Im;

    twiddle_seq_gen dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .ClockEn (ClockEn),
        .Start   (Start),
        .LogN    (LogN),
        .Stage   (Stage),
`ifdef TWIDDLE_CONJ_EN
        .Inv     (Inv),
`endif
        .Busy    (Busy),
        .Valid   (Valid),
        .Last    (Last),
        .Re      (Re),
        .Im      (Im)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int   re;
        int   im;
        logic last;
    } tw_t;

    tw_t  exp_q[$];
    tw_t  got[$];
    tw_t  cur;
    int   nchk = 0;
    int   npass = 0;
    int   exp_n = 0;
    logic mon_en;
    logic last_seen = 1'b0;
    logic [37:0] prev_o = '0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        nchk++;
        assert (obs === expv) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    // Drive one Start pulse; for legal parameters push the whole expected sequence
    task automatic start_seq(input int logn, input int stage, input bit inv);
        bit legal;
        legal = (logn >= 3) && (logn <= 12) && (stage < logn);
        @(negedge Clock);
        got.delete();
        ClockEn = 1'b1;
        LogN    = 4'(logn);
        Stage   = 4'(stage);
`ifdef TWIDDLE_CONJ_EN
        Inv     = inv;
`endif
        Start   = 1'b1;
        exp_n   = 0;
        if (legal) begin
            exp_n = 1 << (logn - 1);
            for (int j = 0; j < exp_n; j++) begin
                int  e;
                int  th;
                real a;
                tw_t x;
                e  = (j & ((1 << stage) - 1)) << (logn - 1 - stage);
                th = e << (12 - logn);
                a  = 2.0 * PI * $itor(th) / 4096.0;
                x.re   = rnd($cos(a) * 65536.0);
                x.im   = rnd(-$sin(a) * 65536.0);
                if (inv) x.im = -x.im;
                x.last = (j == exp_n - 1);
                exp_q.push_back(x);
            end
        end
        @(negedge Clock);
        Start = 1'b0;
        chk($sformatf("busy_after_start_%0d_%0d", logn, stage), Busy, legal);
    endtask

    task automatic wait_done(input int budget, input bit rnd_en);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || Busy) && n < budget) begin
            @(negedge Clock);
            if (rnd_en) ClockEn = 1'($urandom_range(0, 1));
            n++;
        end
        ClockEn = 1'b1;
        nchk++;
        assert (n < budget) npass++;
        else $error("FAIL seq_timeout: observed %0d cycles, expected fewer than %0d", n, budget);
        chk("output_count", got.size(), exp_n);
    endtask

    // Scoreboard monitor: pop on each enabled-edge Valid, require hold on disabled edges
    always @(posedge Clock) begin
        mon_en = ClockEn;
        #1;
        if (Reset) begin
            last_seen = 1'b0;
        end else if (!mon_en) begin
            chk("hold_on_gap", {Valid, Last, Re, Im}, prev_o);
        end else begin
            if (last_seen) begin
                chk("busy_fall", Busy, 0);
                chk("valid_fall", Valid, 0);
                last_seen = 1'b0;
            end
            if (Valid) begin
                got.push_back('{re: int'(Re), im: int'(Im), last: Last});
                nchk++;
                assert (exp_q.size() > 0) npass++;
                else $error("FAIL extra_valid: observed Valid=1 Re=%0d Im=%0d, expected no output", Re, Im);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    chk("re", Re, cur.re);
                    chk("im", Im, cur.im);
                    chk("last", Last, cur.last);
                end
                if (Last) begin
                    chk("busy_at_last", Busy, 1);
                    last_seen = 1'b1;
                end
            end
        end
        prev_o = {Valid, Last, Re, Im};
    end

    initial begin
        Reset   = 1'b1;
        ClockEn = 1'b1;
        Start   = 1'b0;
        LogN    = 4'd3;
        Stage   = 4'd0;
`ifdef TWIDDLE_CONJ_EN
        Inv     = 1'b0;
`endif
        #12;
        chk("rst_busy", Busy, 0);
        chk("rst_valid", Valid, 0);
        chk("rst_last", Last, 0);
        chk("rst_re", Re, 0);
        chk("rst_im", Im, 0);
        @(negedge Clock);
        Reset = 1'b0;

        // Stage 0: all twiddles are W^0
        start_seq(3, 0, 1'b0);
        wait_done(50, 1'b0);

        // Stage 2 of N=8: four distinct quadrant points
        start_seq(3, 2, 1'b0);
        wait_done(50, 1'b0);
        if (got.size() == 4) begin
            chk("s2_re1", got[1].re, 46341);
            chk("s2_im1", got[1].im, -46341);
            chk("s2_re2", got[2].re, 0);
            chk("s2_im2", got[2].im, -65536);
            chk("s2_re3", got[3].re, -46341);
            chk("s2_im3", got[3].im, -46341);
        end

        // Largest size, last stage: theta walks 0..2047
        start_seq(12, 11, 1'b0);
        wait_done(3000, 1'b0);
        if (got.size() == 2048) begin
            chk("big_re_q", got[1024].re, 0);
            chk("big_im_q", got[1024].im, -65536);
            chk("big_re_1", got[1].re, 65536);
            chk("big_im_1", got[1].im, -101);
            chk("big_last_end", got[2047].last, 1);
            chk("big_last_early", got[2046].last, 0);
        end

        // Enable gaps plus a second Start while running
        start_seq(3, 2, 1'b0);
        @(negedge Clock);
        LogN  = 4'd4;
        Stage = 4'd1;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        wait_done(300, 1'b1);

        // Asynchronous reset mid-run
        start_seq(4, 2, 1'b0);
        repeat (5) @(negedge Clock);
        chk("pre_rst_valid", Valid, 1);
        #2 Reset = 1'b1;
        #1;
        chk("abort_busy", Busy, 0);
        chk("abort_valid", Valid, 0);
        chk("abort_last", Last, 0);
        chk("abort_re", Re, 0);
        chk("abort_im", Im, 0);
        exp_q.delete();
        @(negedge Clock);
        Reset = 1'b0;
        repeat (10) @(negedge Clock);
        chk("no_valid_after_abort", Valid, 0);

        // Illegal LogN / Stage are ignored
        start_seq(13, 0, 1'b0);
        start_seq(3, 3, 1'b0);
        start_seq(2, 0, 1'b0);
        repeat (8) @(negedge Clock);
        chk("illegal_no_valid", Valid, 0);
        chk("illegal_no_busy", Busy, 0);

        // Recovery with a legal start after the aborts
        start_seq(4, 3, 1'b0);
        wait_done(60, 1'b0);

`ifdef TWIDDLE_CONJ_EN
        start_seq(3, 2, 1'b1);
        wait_done(50, 1'b0);
        if (got.size() == 4) begin
            chk("conj_re1", got[1].re, 46341);
            chk("conj_im1", got[1].im, 46341);
            chk("conj_im2", got[2].im, 65536);
        end
`endif

        repeat (3) @(negedge Clock);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
